// File: rtl/filter_ctrl_pkg.sv
// Shared types and helpers for the filter buffer load sequencer.
package filter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int WORD_BYTES    = 4;
  localparam int MAX_BUF_BYTES = 256;

  // Word k lands in the most-significant free slot: bit buf_bytes-1-4k.
  function automatic logic [MAX_BUF_BYTES-1:0] word_to_en(input int k, input int buf_bytes);
    logic [MAX_BUF_BYTES-1:0] en;
    en = '0;
    for (int i = 0; i < MAX_BUF_BYTES; i++) begin
      if (i == (buf_bytes - 1 - (WORD_BYTES * k))) begin
        en[i] = 1'b1;
      end else begin
        en[i] = 1'b0;
      end
    end
    return en;
  endfunction

endpackage

// File: rtl/filter_en_decode.sv
// Combinational word index to one-hot filter buffer write enable.
module filter_en_decode
  import filter_ctrl_pkg::*;
#(
  parameter int BUF_BYTES = 16,
  parameter int K_W       = 3
) (
  input  logic [K_W-1:0]       k,
  output logic [BUF_BYTES-1:0] en
);

  // decode word index to its byte-lane enable
  always_comb begin
    en = BUF_BYTES'(word_to_en(int'(k), BUF_BYTES));
  end

endmodule

// File: rtl/filter_load_ctrl.sv
// Filter buffer load sequencer: one word read per cycle, write enable one cycle later.
// Optional double-buffer bank select under macro FILTER_LOAD_CTRL_DBLBUF_EN.
module filter_load_ctrl
  import filter_ctrl_pkg::*;
#(
  parameter  int ADDR_W    = 8,
  parameter  int BUF_BYTES = 16,
  localparam int WORDS     = BUF_BYTES / WORD_BYTES,
  localparam int NW_W      = $clog2(WORDS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [NW_W-1:0]      num_words,
  input  logic                 hold,
  output logic                 mem_rd,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [BUF_BYTES-1:0] buf_en,
  output logic                 busy,
  output logic                 done
`ifdef FILTER_LOAD_CTRL_DBLBUF_EN
  ,
  output logic                 buf_bank
`endif
);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [NW_W-1:0]      n_q, n_d;
  logic [NW_W-1:0]      k_q, k_d;
  logic [BUF_BYTES-1:0] buf_en_q, buf_en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [BUF_BYTES-1:0] dec_en_s;
  logic                 rd_s;
  logic [ADDR_W-1:0]    addr_s;

  filter_en_decode #(
    .BUF_BYTES(BUF_BYTES),
    .K_W      (NW_W)
  ) u_en_decode (
    .k (k_q),
    .en(dec_en_s)
  );

  // read issue follows hold in the same cycle so a paused cycle never strobes memory
  always_comb begin
    rd_s   = 1'b0;
    addr_s = '0;
    if ((state_q == LOAD) && !hold) begin
      rd_s   = 1'b1;
      addr_s = base_q + ADDR_W'(k_q);
    end else begin
      rd_s   = 1'b0;
      addr_s = '0;
    end
  end

  // next-state, latched request and registered status
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    n_d     = n_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d = base_addr;
          k_d    = '0;
          n_d    = (num_words > NW_W'(WORDS)) ? NW_W'(WORDS) : num_words;
          if (num_words == '0) begin
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (!hold) begin
          k_d = k_q + NW_W'(1'b1);
          if (k_q == (n_q - NW_W'(1'b1))) begin
            state_d = DRAIN;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    buf_en_d = rd_s ? dec_en_s : '0;
    busy_d   = (state_d == LOAD) || (state_d == DRAIN);
    done_d   = (state_d == DONE);
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      n_q      <= '0;
      k_q      <= '0;
      buf_en_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      n_q      <= n_d;
      k_q      <= k_d;
      buf_en_q <= buf_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign mem_rd   = rd_s;
  assign mem_addr = addr_s;
  assign buf_en   = buf_en_q;
  assign busy     = busy_q;
  assign done     = done_q;

`ifdef FILTER_LOAD_CTRL_DBLBUF_EN
  logic bank_q, bank_d;

  // flip banks once the done pulse has been seen
  always_comb begin
    if (state_q == DONE) begin
      bank_d = ~bank_q;
    end else begin
      bank_d = bank_q;
    end
  end

  // bank select register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q <= 1'b0;
    end else begin
      bank_q <= bank_d;
    end
  end

  assign buf_bank = bank_q;
`endif

endmodule

// File: tb/tb_filter_load_ctrl.sv
// Self-checking bench for filter_load_ctrl: directed table, corner sequences, random loads.
module tb_filter_load_ctrl;

  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic [7:0]  base_addr = 8'h00;
  logic [2:0]  num_words = 3'd0;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [15:0] buf_en;
  logic        busy;
  logic        done;
`ifdef FILTER_LOAD_CTRL_DBLBUF_EN
  logic        buf_bank;
  int          exp_bank = 0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  filter_load_ctrl #(
    .ADDR_W   (8),
    .BUF_BYTES(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_addr(base_addr),
    .num_words(num_words),
    .hold     (hold),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .buf_en   (buf_en),
    .busy     (busy),
    .done     (done)
`ifdef FILTER_LOAD_CTRL_DBLBUF_EN
    ,
    .buf_bank (buf_bank)
`endif
  );

  typedef struct {
    logic [7:0]  base;
    int          nw;
    logic [31:0] hmask;
    bit          spurious;
    int          exp_reads;
    int          exp_done;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reads happen on the first min(nw,WORDS) cycles after start with hold low.
  function automatic int model_reads(input int nw, input logic [31:0] hmask, output int rel[4]);
    int n;
    int got;
    int r;
    n   = (nw > WORDS) ? WORDS : nw;
    got = 0;
    r   = 1;
    for (int i = 0; i < 4; i++) rel[i] = 0;
    while (got < n) begin
      if (!((r < 32) && hmask[r])) begin
        rel[got] = r;
        got++;
      end
      r++;
    end
    return n;
  endfunction

  task automatic run_load(input string tag, input logic [7:0] base, input int nw,
                          input logic [31:0] hmask, input bit spurious,
                          input int tbl_reads, input int tbl_done);
    int          n;
    int          done_rel;
    int          rel[4];
    int          obs_reads;
    int          obs_en;
    int          obs_done;
    logic [7:0]  obs_addr[4];
    int          obs_rrel[4];
    logic [15:0] obs_env[4];
    int          obs_erel[4];
    logic [15:0] exp_en;
    n         = model_reads(nw, hmask, rel);
    done_rel  = (n == 0) ? 1 : rel[n-1] + 2;
    obs_reads = 0;
    obs_en    = 0;
    obs_done  = -1;
    for (int i = 0; i < 4; i++) begin
      obs_addr[i] = 8'h00; obs_rrel[i] = 0; obs_env[i] = 16'h0000; obs_erel[i] = 0;
    end
    for (int r = 0; r < 40; r++) begin
      @(negedge clk);
      if (r == 0) begin
        start = 1'b1; base_addr = base; num_words = 3'(nw); hold = 1'b0;
      end else begin
        start     = spurious && (r == 2);
        base_addr = spurious ? 8'hAA : base;
        num_words = 3'd2;
        hold      = (r < 32) ? hmask[r] : 1'b0;
      end
      #1;
      check($sformatf("%s.busy@%0d", tag, r), {31'd0, busy}, {31'd0, (r >= 1) && (r < done_rel)});
      check($sformatf("%s.done@%0d", tag, r), {31'd0, done}, {31'd0, r == done_rel});
`ifdef FILTER_LOAD_CTRL_DBLBUF_EN
      check($sformatf("%s.bank@%0d", tag, r), {31'd0, buf_bank}, 32'(exp_bank));
`endif
      if (mem_rd === 1'b1) begin
        if (obs_reads < 4) begin
          obs_addr[obs_reads] = mem_addr;
          obs_rrel[obs_reads] = r;
        end
        obs_reads++;
      end
      if (buf_en !== 16'h0000) begin
        if (obs_en < 4) begin
          obs_env[obs_en]  = buf_en;
          obs_erel[obs_en] = r;
        end
        obs_en++;
      end
      if ((done === 1'b1) && (obs_done < 0)) obs_done = r;
      if (r == done_rel) break;
    end
    start = 1'b0;
    hold  = 1'b0;
`ifdef FILTER_LOAD_CTRL_DBLBUF_EN
    exp_bank = exp_bank ^ 1;
`endif
    check($sformatf("%s.nreads", tag), 32'(obs_reads), 32'(n));
    check($sformatf("%s.nen", tag), 32'(obs_en), 32'(n));
    for (int i = 0; i < n; i++) begin
      exp_en = 16'h8000 >> (4 * i);
      check($sformatf("%s.addr%0d", tag, i), {24'd0, obs_addr[i]}, {24'd0, 8'(base + 8'(i))});
      check($sformatf("%s.rdcyc%0d", tag, i), 32'(obs_rrel[i]), 32'(rel[i]));
      check($sformatf("%s.en%0d", tag, i), {16'd0, obs_env[i]}, {16'd0, exp_en});
      check($sformatf("%s.encyc%0d", tag, i), 32'(obs_erel[i]), 32'(rel[i] + 1));
    end
    if (tbl_reads >= 0) begin
      check($sformatf("%s.tbl_reads", tag), 32'(obs_reads), 32'(tbl_reads));
      check($sformatf("%s.tbl_done", tag), 32'(obs_done), 32'(tbl_done));
    end
  endtask

  initial begin
    vecs[0] = '{8'h10, 4, 32'h0000_0000, 1'b0, 4, 6};
    vecs[1] = '{8'h20, 3, 32'h0000_000C, 1'b0, 3, 7};
    vecs[2] = '{8'h30, 0, 32'h0000_0000, 1'b0, 0, 1};
    vecs[3] = '{8'h40, 7, 32'h0000_0000, 1'b0, 4, 6};
    vecs[4] = '{8'hFE, 4, 32'h0000_0000, 1'b0, 4, 6};
    vecs[5] = '{8'h50, 1, 32'h0000_0002, 1'b0, 1, 4};
    vecs[6] = '{8'h60, 4, 32'h0000_002A, 1'b0, 4, 9};
    vecs[7] = '{8'hA0, 4, 32'h0000_0000, 1'b1, 4, 6};
    vecs[8] = '{8'hC0, 2, 32'h0000_0018, 1'b0, 2, 4};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst.mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst.mem_addr", {24'd0, mem_addr}, 32'd0);
    check("rst.buf_en", {16'd0, buf_en}, 32'd0);
    check("rst.busy", {31'd0, busy}, 32'd0);
    check("rst.done", {31'd0, done}, 32'd0);
`ifdef FILTER_LOAD_CTRL_DBLBUF_EN
    check("rst.bank", {31'd0, buf_bank}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;

    for (int v = 0; v < 9; v++) begin
      run_load($sformatf("vec%0d", v), vecs[v].base, vecs[v].nw, vecs[v].hmask,
               vecs[v].spurious, vecs[v].exp_reads, vecs[v].exp_done);
    end

    // Asynchronous reset in the middle of a load, then a clean load.
    @(negedge clk);
    start = 1'b1; base_addr = 8'h70; num_words = 3'd4; hold = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    check("mid.mem_rd_before", {31'd0, mem_rd}, 32'd1);
    check("mid.buf_en_before", {16'd0, buf_en}, 32'h0000_8000);
    #1;
    rst = 1'b0;
    #1;
    check("mid.mem_rd", {31'd0, mem_rd}, 32'd0);
    check("mid.mem_addr", {24'd0, mem_addr}, 32'd0);
    check("mid.buf_en", {16'd0, buf_en}, 32'd0);
    check("mid.busy", {31'd0, busy}, 32'd0);
    check("mid.done", {31'd0, done}, 32'd0);
`ifdef FILTER_LOAD_CTRL_DBLBUF_EN
    exp_bank = 0;
    check("mid.bank", {31'd0, buf_bank}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    run_load("after_rst", 8'h33, 4, 32'h0, 1'b0, 4, 6);

    for (int t = 0; t < 25; t++) begin
      run_load($sformatf("rnd%0d", t), 8'($urandom), int'($urandom_range(0, 7)),
               $urandom & 32'h0000_FFFE, 1'($urandom_range(0, 1)), -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/filter_load_ctrl.md
Name: filter_load_ctrl

Overview:
Sequencer that fills the 16-byte filter buffer from filter memory before each convolution pass.
- Issues one 4-byte memory read per cycle.
- Generates the one-hot 16-bit buffer enable, aligned with the 1-cycle memory read latency.
- Reports completion to the top-level CNN controller with a start/busy/done handshake.
- Sits between the main CNN FSM, the filter memory and the filter buffer.

Parameters:
- ADDR_W, 8, filter memory word-address width.
- BUF_BYTES, 16, filter buffer depth in bytes; must be a multiple of 4.
- WORDS, BUF_BYTES/4, number of 4-byte words in the buffer (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  load request; sampled only in IDLE.
- base_addr  in  ADDR_W  first memory word of the filter; latched on accepted start.
- num_words  in  $clog2(WORDS+1)  words to load; latched on accepted start.
- hold  in  1  pause; no new read is issued while high.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  ADDR_W  read address, valid when mem_rd=1.
- buf_en  out  BUF_BYTES  one-hot buffer write enable; bit BUF_BYTES-1-4k selects word k.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst=0): state=IDLE, all outputs 0, internal counter k=0, latched registers 0.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE
  - start=1 latches base_addr and n = min(num_words, WORDS); next state LOAD, busy=1 the following cycle.
  - If num_words=0: go straight to DONE; no reads issued.
- LOAD
  - Each cycle with hold=0: mem_rd=1, mem_addr = base+k (mod 2^ADDR_W), k++.
  - When the read for k=n-1 is issued, next state is DRAIN.
  - hold=1: mem_rd=0, k unchanged, state unchanged.
- Write alignment
  - buf_en is a registered copy of the one-hot decode of the k issued in the previous cycle.
  - For a read at cycle t, buf_en is asserted at t+1, when mem data is presented on the buffer dataIn.
  - buf_en=0 in every cycle not following a read.
- DRAIN: one cycle; carries the final buf_en; then DONE.
- DONE: done=1 for exactly one cycle, busy=0 from the same cycle; next state IDLE.
- start while busy=1 is ignored; it is not queued.
- hold asserted in DRAIN or DONE has no effect; the outstanding write always completes.
- num_words > WORDS clamps to WORDS; there is no error output.
- Latency: start accepted at cycle c with n words and no hold gives done at cycle c+n+2.
- Reset mid-operation aborts immediately; partial buffer contents are not cleared.

Optional Feature:
- Macro: FILTER_LOAD_CTRL_DBLBUF_EN.
- With macro defined:
  - Extra output port buf_bank (1 bit) selects which of two filter buffer banks receives writes.
  - buf_bank resets to 0 and toggles on the cycle after each done pulse.
  - The toggle also occurs for num_words=0 loads.
  - busy/done timing is unchanged.
- Without macro: buf_bank port is absent; single buffer; behaviour otherwise identical.

Decomposition:
- Package filter_ctrl_pkg holds:
  - state enum {IDLE, LOAD, DRAIN, DONE};
  - WORD_BYTES=4;
  - function word_to_en(k) returning the one-hot enable.
- One sub-module, filter_en_decode:
  - combinational k -> one-hot BUF_BYTES enable;
  - instantiated once, feeding the buf_en register.

Test Plan:
- Basic load:
  - Stimulus: reset, then start with base_addr=8'h10, num_words=4, hold=0.
  - Response: mem_addr 10,11,12,13 on consecutive cycles.
  - Response: buf_en 16'h8000, 16'h0800, 16'h0080, 16'h0008, each one cycle after its read.
  - Response: done exactly 6 cycles after start accepted.
- Hold mid-load:
  - Stimulus: num_words=3, hold=1 for 2 cycles after the first read.
  - Response: mem_rd=0 during hold, addresses still contiguous, no duplicate buf_en, done 2 cycles later than unheld.
- Edge counts:
  - num_words=0: done 1 cycle after start, mem_rd never asserted.
  - num_words=7 (WORDS=4): exactly 4 reads.
- Address wrap: base_addr=8'hFE, num_words=4 -> mem_addr FE, FF, 00, 01.
- Start while busy and async reset:
  - Second start during LOAD is ignored (read count stays 4).
  - rst low mid-LOAD: all outputs 0 asynchronously; a new start after release behaves as a clean load.
- With FILTER_LOAD_CTRL_DBLBUF_EN defined:
  - buf_bank = 0 during first load, 1 during second, 0 during third.
